// File: rtl/hamming_pkg.sv
// hamming_pkg: shared sizing helpers, position mapping and status codes for the SEC-DED codec
package hamming_pkg;
  localparam logic [1:0] ST_OK = 2'b00, ST_CORR = 2'b01, ST_DERR = 2'b10;
  function automatic int calc_pw(input int dw);
    int r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction
  function automatic bit is_pow2(input int x);
    return x > 0 && (x & (x - 1)) == 0;
  endfunction
  function automatic int pos_to_idx(input int pos);
    int idx = 0;
    for (int p = 3; p < pos; p++) if (!is_pow2(p)) idx++;
    return idx;
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome, overall-parity mismatch and data extraction (code in; syn, mis, data out)
module hamming_syndrome import hamming_pkg::*; #(
  parameter int DATA_W = 6,
  localparam int P_W = calc_pw(DATA_W),
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [P_W-1:0]    syn,
  output logic              mis,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    syn = '0;
    for (int p = 1; p < CODE_W; p++) if (code[p]) syn = syn ^ P_W'(p);
  end
  assign mis = ^code;
  for (genvar i = 1; i < CODE_W; i++) begin : g_pos
    if (!is_pow2(i)) begin : g_dat
      assign data[pos_to_idx(i)] = code[i];
    end
  end
endmodule

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage valid/ready SEC-DED encode/decode pipeline with saturating error counters
module hamming_secded_pipe import hamming_pkg::*; #(
  parameter int DATA_W = 6,
  parameter int CNT_W = 8,
  localparam int P_W = calc_pw(DATA_W),
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [CODE_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_word,
  output logic [1:0]        out_status,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  derr_cnt
);
  logic adv, v1, m1, mis_c, mis1;
  logic [CODE_W-1:0] placed, raw_c, raw1, pw, res_word;
  logic [P_W-1:0] syn_c, syn1;
  logic [DATA_W-1:0] dat_c, dat1, flip;
  logic [1:0] res_status;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign placed[0] = 1'b0;
  for (genvar i = 1; i < CODE_W; i++) begin : g_pos
    if (is_pow2(i)) begin : g_par
      assign placed[i] = 1'b0;
    end else begin : g_dat
      assign placed[i] = in_word[pos_to_idx(i)];
      assign flip[pos_to_idx(i)] = mis1 && int'(syn1) == i;
    end
  end
  assign raw_c = mode ? in_word : placed;
  hamming_syndrome #(.DATA_W(DATA_W)) u_syn (.code(raw_c), .syn(syn_c), .mis(mis_c), .data(dat_c));
  always_comb begin
    pw = '0;
    for (int k = 0; k < P_W; k++) pw[1 << k] = syn1[k];
    pw[0] = mis1 ^ (^syn1);
  end
  assign res_word = m1 ? CODE_W'(dat1 ^ flip) : raw1 | pw;
  assign res_status = !m1 ? ST_OK :
                      mis1 ? (int'(syn1) < CODE_W ? ST_CORR : ST_DERR) :
                      (syn1 == '0 ? ST_OK : ST_DERR);
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      out_valid <= 1'b0;
      out_word <= '0;
      out_status <= ST_OK;
    end else if (adv) begin
      v1 <= in_valid;
      m1 <= mode;
      raw1 <= raw_c;
      syn1 <= syn_c;
      mis1 <= mis_c;
      dat1 <= dat_c;
      out_valid <= v1;
      out_word <= res_word;
      out_status <= res_status;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      corr_cnt <= '0;
      derr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_status == ST_CORR && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      if (out_status == ST_DERR && derr_cnt != '1) derr_cnt <= derr_cnt + 1'b1;
    end
  end
endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
- Parametrised Hamming SEC-DED codec. Encodes DATA_W-bit data into a CODE_W-bit codeword, or decodes and corrects a codeword, selected per transaction by `mode`.
- Two-stage pipeline with valid/ready handshake on both sides.
- Saturating counters for corrected and uncorrectable errors.
- Successor to the fixed 6-bit lab Hamming block; sits between the datapath and the memory/link model.

Parameters:
- DATA_W, 6, data bits per word (≥1).
- P_W, derived localparam, smallest r with 2^r ≥ DATA_W+r+1 (4 for DATA_W=6).
- CODE_W, derived localparam, DATA_W+P_W+1 (11 for default).
- CNT_W, 8, width of error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- mode  in  1  0 = encode, 1 = decode; sampled with input word.
- in_word  in  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_word  out  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
- out_status  out  2  00 OK, 01 single error corrected, 10 uncorrectable, 11 unused.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of decode results with status 01.
- derr_cnt  out  CNT_W  count of decode results with status 10.

Behaviour:
- Codeword layout:
  - Bit i holds Hamming position i for i = 1..CODE_W-1.
  - Parity bits sit at power-of-two positions. Parity bit at 2^k = XOR of all positions with bit k set.
  - Data bits fill the non-power-of-two positions in ascending order, data LSB first. Default: d0..d5 at positions 3, 5, 6, 7, 9, 10.
  - Bit 0 is the overall parity: even parity over bits 1..CODE_W-1, so the XOR of all CODE_W bits is 0.
- Pipeline:
  - S1 registers mode, raw word, syndrome (P_W bits) and overall-parity mismatch (encode: computed parity bits).
  - S2 registers out_word and out_status.
  - Latency is exactly 2 cycles from accept to out_valid when not stalled.
  - Throughput is 1 word per cycle.
- Handshake:
  - adv = !out_valid || out_ready. in_ready = adv.
  - Both stages advance only when adv; bubbles propagate as invalid.
  - Input accepted when in_valid && in_ready.
  - While out_valid && !out_ready: out_word, out_status and out_valid hold stable, and S1 holds.
- Decode classification (syndrome s, overall mismatch m):
  - s=0, m=0 → 00, data unchanged.
  - m=1, s=0 → 01; overall-parity bit was in error, data unchanged.
  - m=1, 1 ≤ s ≤ CODE_W-1 → 01; flip position s, then extract data.
  - m=1, s ≥ CODE_W → 10; data extracted uncorrected.
  - m=0, s≠0 → 10; data extracted uncorrected.
- Encode: out_status always 00; counters untouched.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) of a decode result with the matching status.
  - Saturate at 2^CNT_W-1, no wrap.
  - clr_cnt and increment in the same cycle → 0 (clear wins).
- Reset:
  - out_valid=0, out_word=0, out_status=00, corr_cnt=0, derr_cnt=0; S1 valid cleared.
  - Reset mid-operation drops in-flight words, with no counter update.
  - in_ready=1 in the first cycle after reset.
- Mode mixing: each word carries its own mode through the pipeline; alternating encode/decode words back-to-back is legal.

Decomposition:
- Package hamming_pkg:
  - Function for P_W calculation.
  - is_pow2 function.
  - Position-to-data-index mapping function.
  - Status constants ST_OK, ST_CORR, ST_DERR.
- Sub-module hamming_syndrome (combinational, parameter DATA_W):
  - Inputs: codeword.
  - Outputs: syndrome, overall mismatch, extracted data.
  - Shared by the encode parity path, which applies it to the codeword with parity fields zeroed.

Test Plan:
- Encode d=6'h01 → out_word 11'h00F, status 00, out_valid 2 cycles after accept. Encode 6'h00 → 11'h000.
- Decode 11'h00F → data 6'h01/00. Decode 11'h02F (pos5 flipped) → data 6'h01/01, corr_cnt=1. Decode 11'h00E (bit0 flipped) → data 6'h01/01, corr_cnt=2.
- Decode 11'h06F (pos5, pos6 flipped) → data 6'h07/10, derr_cnt=1. Exhaustive single-bit flips over all 64 data values → all status 01 with correct data.
- Back-to-back stream of 8 words with out_ready low for cycles 3–5 → no loss, duplication or reorder; outputs held stable while stalled.
- Drive 300 corrected words → corr_cnt saturates at 255. clr_cnt coincident with a corrected handshake → corr_cnt=0.
- Assert rst with 2 words in flight → out_valid=0, counters 0 next cycle, no stale output after reset deasserts.
